mc_ctrl_fsm: RTL and testbench

Parametrised multicycle MIPS control unit: next-generation successor to the fixed-latency controller.
Adds a variable-latency memory handshake (mem_req/mem_rdy) with a wait timeout, jal/jr/bgtz support, an error state, and retired-instruction/cycle performance counters.
Drives the multicycle datapath's write enables and mux selects; all outputs decode from current state plus zero/more/mem_rdy.

---
 rtl/mc_pkg.sv | 73 +++++++
 rtl/mc_wait_timer.sv | 32 +++
 rtl/mc_ctrl_fsm.sv | 185 ++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes and
// datapath mux-select codes, plus the DECODE dispatch table.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXE_R,
      S_WB_R,
      S_EXE_I,
      S_WB_I,
      S_MEM_ADR,
      S_MEM_RD,
      S_WB_MEM,
      S_MEM_WR,
      S_BR,
      S_JMP,
      S_JR,
      S_ERR
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_BGTZ  = 6'h07;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_JR    = 6'h08;

   localparam logic [1:0] PC_PLUS4   = 2'b00;
   localparam logic [1:0] PC_BRANCH  = 2'b01;
   localparam logic [1:0] PC_JUMP    = 2'b10;
   localparam logic [1:0] PC_RS      = 2'b11;

   localparam logic [1:0] DST_RT     = 2'b00;
   localparam logic [1:0] DST_RD     = 2'b01;
   localparam logic [1:0] DST_RA     = 2'b10;

   localparam logic [1:0] M2R_ALU    = 2'b00;
   localparam logic [1:0] M2R_MEM    = 2'b01;
   localparam logic [1:0] M2R_PC4    = 2'b10;

   localparam logic [1:0] EXT_ZERO   = 2'b00;
   localparam logic [1:0] EXT_SIGN   = 2'b01;
   localparam logic [1:0] EXT_LUI    = 2'b10;

   localparam logic [1:0] ALU_ADD    = 2'b00;
   localparam logic [1:0] ALU_SUB    = 2'b01;
   localparam logic [1:0] ALU_FUNCT  = 2'b10;
   localparam logic [1:0] ALU_OR     = 2'b11;

   // State entered from DECODE for a given instruction word.
   function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         OP_RTYPE:                 return (fn == FN_JR) ? S_JR : S_EXE_R;
         OP_ADDI, OP_ORI, OP_LUI:  return S_EXE_I;
         OP_LW, OP_SW:             return S_MEM_ADR;
         OP_BEQ, OP_BNE, OP_BGTZ:  return S_BR;
         OP_J, OP_JAL:             return S_JMP;
         default:                  return S_ERR;
      endcase
   endfunction

   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts stalled request cycles and flags a timeout in the
// last allowed cycle unless the memory completes in that same cycle.
module mc_wait_timer #(
   parameter int unsigned WAIT_W   = 8,
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic req,
   input  logic rdy,
   output logic timeout_c
);

   logic [WAIT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || start || (req && rdy))
         cnt <= '0;
      else if (req)
         cnt <= cnt + WAIT_W'(1);
   end

   generate
      if (MAX_WAIT == 0) begin : g_no_timeout
         assign timeout_c = 1'b0;
      end else begin : g_timeout
         assign timeout_c = req && !rdy && (cnt == WAIT_W'(MAX_WAIT - 1));
      end
   endgenerate

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control unit with variable-latency memory handshake, wait
// timeout, sticky error state and retired-instruction/cycle counters.
module mc_ctrl_fsm
   import mc_pkg::*;
#(
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned WAIT_W   = 8,
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             more,
   input  logic             mem_rdy,
   output logic             mem_req,
   output logic             mem_we,
   output logic             pc_wr,
   output logic             ir_wr,
   output logic [1:0]       pc_src,
   output logic [1:0]       reg_dst,
   output logic             alu_src,
   output logic [1:0]       mem_to_reg,
   output logic             reg_we,
   output logic [1:0]       ext_op,
   output logic [1:0]       alu_op,
   output logic             err,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [CNT_W-1:0] cycle_cnt
);

   state_t            state;
   state_t            next;
   logic              timeout_c;
   logic              wait_start;
   logic [CNT_W-1:0]  instr_q;
   logic [CNT_W-1:0]  cycle_q;

   assign wait_start = is_mem_state(next) && (next != state);

   mc_wait_timer #(
      .WAIT_W   (WAIT_W),
      .MAX_WAIT (MAX_WAIT)
   ) u_wait (
      .clk       (clk),
      .rst       (rst),
      .start     (wait_start),
      .req       (mem_req),
      .rdy       (mem_rdy),
      .timeout_c (timeout_c)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_FETCH;
      else
         state <= next;
   end

   // Retirement is any return to FETCH; ERR freezes the cycle counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q <= '0;
         cycle_q <= '0;
      end else begin
         if (state != S_ERR)
            cycle_q <= cycle_q + CNT_W'(1);
         if ((next == S_FETCH) && (state != S_FETCH))
            instr_q <= instr_q + CNT_W'(1);
      end
   end

   assign instr_cnt = rst ? '0 : instr_q;
   assign cycle_cnt = rst ? '0 : cycle_q;

   always_comb begin
      next = state;
      case (state)
         S_FETCH:   if (timeout_c) next = S_ERR;
                    else if (mem_rdy) next = S_DECODE;
         S_DECODE:  next = dispatch(opcode, funct);
         S_EXE_R:   next = S_WB_R;
         S_WB_R:    next = S_FETCH;
         S_EXE_I:   next = S_WB_I;
         S_WB_I:    next = S_FETCH;
         S_MEM_ADR: next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:  if (timeout_c) next = S_ERR;
                    else if (mem_rdy) next = S_WB_MEM;
         S_WB_MEM:  next = S_FETCH;
         S_MEM_WR:  if (timeout_c) next = S_ERR;
                    else if (mem_rdy) next = S_FETCH;
         S_BR:      next = S_FETCH;
         S_JMP:     next = S_FETCH;
         S_JR:      next = S_FETCH;
         S_ERR:     next = S_ERR;
         default:   next = S_ERR;
      endcase
   end

   // Datapath controls decode from state; reset forces everything low.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      pc_wr      = 1'b0;
      ir_wr      = 1'b0;
      pc_src     = PC_PLUS4;
      reg_dst    = DST_RT;
      alu_src    = 1'b0;
      mem_to_reg = M2R_ALU;
      reg_we     = 1'b0;
      ext_op     = EXT_ZERO;
      alu_op     = ALU_ADD;
      err        = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               mem_req = 1'b1;
               if (mem_rdy) begin
                  ir_wr  = 1'b1;
                  pc_wr  = 1'b1;
                  pc_src = PC_PLUS4;
               end
            end
            S_EXE_R: alu_op = ALU_FUNCT;
            S_WB_R: begin
               reg_we     = 1'b1;
               reg_dst    = DST_RD;
               mem_to_reg = M2R_ALU;
               alu_op     = ALU_FUNCT;
            end
            S_EXE_I, S_WB_I: begin
               alu_src = 1'b1;
               reg_we  = (state == S_WB_I);
               reg_dst = DST_RT;
               case (opcode)
                  OP_ADDI: begin ext_op = EXT_SIGN; alu_op = ALU_ADD; end
                  OP_ORI:  begin ext_op = EXT_ZERO; alu_op = ALU_OR;  end
                  OP_LUI:  begin ext_op = EXT_LUI;  alu_op = ALU_OR;  end
                  default: ;
               endcase
            end
            S_MEM_ADR: begin
               alu_src = 1'b1;
               ext_op  = EXT_SIGN;
               alu_op  = ALU_ADD;
            end
            S_MEM_RD: mem_req = 1'b1;
            S_WB_MEM: begin
               reg_we     = 1'b1;
               reg_dst    = DST_RT;
               mem_to_reg = M2R_MEM;
            end
            S_MEM_WR: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
            end
            S_BR: begin
               alu_op = ALU_SUB;
               ext_op = EXT_SIGN;
               pc_src = PC_BRANCH;
               pc_wr  = ((opcode == OP_BEQ)  &&  zero) ||
                        ((opcode == OP_BNE)  && !zero) ||
                        ((opcode == OP_BGTZ) &&  more);
            end
            S_JMP: begin
               pc_wr  = 1'b1;
               pc_src = PC_JUMP;
               if (opcode == OP_JAL) begin
                  reg_we     = 1'b1;
                  reg_dst    = DST_RA;
                  mem_to_reg = M2R_PC4;
               end
            end
            S_JR: begin
               pc_wr  = 1'b1;
               pc_src = PC_RS;
            end
            S_ERR: err = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm (instantiated with MAX_WAIT=4).
module tb_mc_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        more;
   logic        mem_rdy;
   logic        mem_req;
   logic        mem_we;
   logic        pc_wr;
   logic        ir_wr;
   logic [1:0]  pc_src;
   logic [1:0]  reg_dst;
   logic        alu_src;
   logic [1:0]  mem_to_reg;
   logic        reg_we;
   logic [1:0]  ext_op;
   logic [1:0]  alu_op;
   logic        err;
   logic [31:0] instr_cnt;
   logic [31:0] cycle_cnt;

   int          n_checks = 0;
   int          n_fails  = 0;
   int          exp_instr = 0;
   int          exp_cycle = 0;

   // {mem_req, mem_we, pc_wr, ir_wr, pc_src, reg_dst, alu_src, mem_to_reg, reg_we, ext_op, alu_op, err}
   logic [16:0] obs;
   assign obs = {mem_req, mem_we, pc_wr, ir_wr, pc_src, reg_dst, alu_src,
                 mem_to_reg, reg_we, ext_op, alu_op, err};

   localparam logic [16:0] V_ZERO  = 17'b0_0_0_0_00_00_0_00_0_00_00_0;
   localparam logic [16:0] V_FWAIT = 17'b1_0_0_0_00_00_0_00_0_00_00_0;
   localparam logic [16:0] V_FRDY  = 17'b1_0_1_1_00_00_0_00_0_00_00_0;
   localparam logic [16:0] V_EXR   = 17'b0_0_0_0_00_00_0_00_0_00_10_0;
   localparam logic [16:0] V_WBR   = 17'b0_0_0_0_00_01_0_00_1_00_10_0;
   localparam logic [16:0] V_MADR  = 17'b0_0_0_0_00_00_1_00_0_01_00_0;
   localparam logic [16:0] V_MRD   = 17'b1_0_0_0_00_00_0_00_0_00_00_0;
   localparam logic [16:0] V_WBM   = 17'b0_0_0_0_00_00_0_01_1_00_00_0;
   localparam logic [16:0] V_MWR   = 17'b1_1_0_0_00_00_0_00_0_00_00_0;
   localparam logic [16:0] V_BRT   = 17'b0_0_1_0_01_00_0_00_0_01_01_0;
   localparam logic [16:0] V_BRN   = 17'b0_0_0_0_01_00_0_00_0_01_01_0;
   localparam logic [16:0] V_J     = 17'b0_0_1_0_10_00_0_00_0_00_00_0;
   localparam logic [16:0] V_JAL   = 17'b0_0_1_0_10_10_0_10_1_00_00_0;
   localparam logic [16:0] V_JR    = 17'b0_0_1_0_11_00_0_00_0_00_00_0;
   localparam logic [16:0] V_ERR   = 17'b0_0_0_0_00_00_0_00_0_00_00_1;

   always #5 clk = ~clk;

   mc_ctrl_fsm #(
      .CNT_W    (32),
      .WAIT_W   (8),
      .MAX_WAIT (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .more       (more),
      .mem_rdy    (mem_rdy),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .pc_wr      (pc_wr),
      .ir_wr      (ir_wr),
      .pc_src     (pc_src),
      .reg_dst    (reg_dst),
      .alu_src    (alu_src),
      .mem_to_reg (mem_to_reg),
      .reg_we     (reg_we),
      .ext_op     (ext_op),
      .alu_op     (alu_op),
      .err        (err),
      .instr_cnt  (instr_cnt),
      .cycle_cnt  (cycle_cnt)
   );

   task automatic test_reset();
      rst = 1'b1; mem_rdy = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b1; more = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== V_ZERO) begin
            n_fails++;
            $display("FAIL reset_outs cyc%0d: got %b want %b", i, obs, V_ZERO);
         end
         n_checks++;
         if (instr_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
            n_fails++;
            $display("FAIL reset_cnts cyc%0d: got %0d/%0d want 0/0", i, instr_cnt, cycle_cnt);
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
      exp_instr = 0;
      exp_cycle = 0;
   endtask

   task automatic test_rtype();
      logic [16:0] ev [4];
      ev = '{V_FRDY, V_ZERO, V_EXR, V_WBR};
      opcode = 6'h00; funct = 6'h20; zero = 1'b0; more = 1'b0; mem_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== ev[i]) begin
            n_fails++;
            $display("FAIL rtype cyc%0d: got %b want %b", i, obs, ev[i]);
         end
         @(posedge clk); #1;
      end
      exp_instr += 1;
      exp_cycle += 4;
      n_checks++;
      if (instr_cnt !== 32'(exp_instr) || cycle_cnt !== 32'(exp_cycle)) begin
         n_fails++;
         $display("FAIL rtype_cnts: got %0d/%0d want %0d/%0d", instr_cnt, cycle_cnt, exp_instr, exp_cycle);
      end
   endtask

   task automatic test_lw();
      logic [16:0] ev [8];
      logic        rd [8];
      ev = '{V_FRDY, V_ZERO, V_MADR, V_MRD, V_MRD, V_MRD, V_MRD, V_WBM};
      rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      opcode = 6'h23; funct = 6'h00;
      for (int i = 0; i < 8; i++) begin
         mem_rdy = rd[i];
         @(negedge clk);
         n_checks++;
         if (obs !== ev[i]) begin
            n_fails++;
            $display("FAIL lw cyc%0d: got %b want %b", i, obs, ev[i]);
         end
         @(posedge clk); #1;
      end
      exp_instr += 1;
      exp_cycle += 8;
      n_checks++;
      if (instr_cnt !== 32'(exp_instr) || cycle_cnt !== 32'(exp_cycle)) begin
         n_fails++;
         $display("FAIL lw_cnts: got %0d/%0d want %0d/%0d", instr_cnt, cycle_cnt, exp_instr, exp_cycle);
      end
   endtask

   task automatic test_branch();
      logic [5:0]  op [6];
      logic        zr [6];
      logic        mr [6];
      logic [16:0] bv [6];
      logic [16:0] ev;
      op = '{6'h04, 6'h05, 6'h07, 6'h04, 6'h07, 6'h05};
      zr = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
      mr = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
      bv = '{V_BRN, V_BRT, V_BRT, V_BRT, V_BRN, V_BRN};
      mem_rdy = 1'b1; funct = 6'h00;
      for (int k = 0; k < 6; k++) begin
         opcode = op[k]; zero = zr[k]; more = mr[k];
         for (int i = 0; i < 3; i++) begin
            ev = (i == 0) ? V_FRDY : (i == 1) ? V_ZERO : bv[k];
            @(negedge clk);
            n_checks++;
            if (obs !== ev) begin
               n_fails++;
               $display("FAIL branch%0d cyc%0d: got %b want %b", k, i, obs, ev);
            end
            @(posedge clk); #1;
         end
      end
      exp_instr += 6;
      exp_cycle += 18;
      n_checks++;
      if (instr_cnt !== 32'(exp_instr) || cycle_cnt !== 32'(exp_cycle)) begin
         n_fails++;
         $display("FAIL branch_cnts: got %0d/%0d want %0d/%0d", instr_cnt, cycle_cnt, exp_instr, exp_cycle);
      end
   endtask

   task automatic test_jump();
      logic [5:0]  op [3];
      logic [5:0]  fn [3];
      logic [16:0] jv [3];
      logic [16:0] ev;
      op = '{6'h02, 6'h03, 6'h00};
      fn = '{6'h00, 6'h00, 6'h08};
      jv = '{V_J,   V_JAL, V_JR};
      mem_rdy = 1'b1; zero = 1'b0; more = 1'b0;
      for (int k = 0; k < 3; k++) begin
         opcode = op[k]; funct = fn[k];
         for (int i = 0; i < 3; i++) begin
            ev = (i == 0) ? V_FRDY : (i == 1) ? V_ZERO : jv[k];
            @(negedge clk);
            n_checks++;
            if (obs !== ev) begin
               n_fails++;
               $display("FAIL jump%0d cyc%0d: got %b want %b", k, i, obs, ev);
            end
            @(posedge clk); #1;
         end
      end
      exp_instr += 3;
      exp_cycle += 9;
      n_checks++;
      if (instr_cnt !== 32'(exp_instr) || cycle_cnt !== 32'(exp_cycle)) begin
         n_fails++;
         $display("FAIL jump_cnts: got %0d/%0d want %0d/%0d", instr_cnt, cycle_cnt, exp_instr, exp_cycle);
      end
   endtask

   task automatic test_itype();
      logic [5:0]  op [3];
      logic [16:0] xv [3];
      logic [16:0] wv [3];
      logic [16:0] ev;
      op = '{6'h08, 6'h0D, 6'h0F};
      xv = '{17'b0_0_0_0_00_00_1_00_0_01_00_0,
             17'b0_0_0_0_00_00_1_00_0_00_11_0,
             17'b0_0_0_0_00_00_1_00_0_10_11_0};
      wv = '{17'b0_0_0_0_00_00_1_00_1_01_00_0,
             17'b0_0_0_0_00_00_1_00_1_00_11_0,
             17'b0_0_0_0_00_00_1_00_1_10_11_0};
      mem_rdy = 1'b1; funct = 6'h00;
      for (int k = 0; k < 3; k++) begin
         opcode = op[k];
         for (int i = 0; i < 4; i++) begin
            ev = (i == 0) ? V_FRDY : (i == 1) ? V_ZERO : (i == 2) ? xv[k] : wv[k];
            @(negedge clk);
            n_checks++;
            if (obs !== ev) begin
               n_fails++;
               $display("FAIL itype%0d cyc%0d: got %b want %b", k, i, obs, ev);
            end
            @(posedge clk); #1;
         end
      end
      exp_instr += 3;
      exp_cycle += 12;
      n_checks++;
      if (instr_cnt !== 32'(exp_instr) || cycle_cnt !== 32'(exp_cycle)) begin
         n_fails++;
         $display("FAIL itype_cnts: got %0d/%0d want %0d/%0d", instr_cnt, cycle_cnt, exp_instr, exp_cycle);
      end
   endtask

   // sw with mem_rdy arriving exactly in the last allowed wait cycle, twice.
   task automatic test_wait_edge();
      logic [16:0] ev [11];
      logic        rd [11];
      ev = '{V_FWAIT, V_FWAIT, V_FWAIT, V_FRDY, V_ZERO, V_MADR,
             V_MWR, V_MWR, V_MWR, V_MWR, V_FRDY};
      rd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
             1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      opcode = 6'h2B; funct = 6'h00;
      for (int i = 0; i < 11; i++) begin
         mem_rdy = rd[i];
         @(negedge clk);
         n_checks++;
         if (obs !== ev[i]) begin
            n_fails++;
            $display("FAIL wait_edge cyc%0d: got %b want %b", i, obs, ev[i]);
         end
         @(posedge clk); #1;
      end
      // last checked cycle began the next fetch (rdy=1), moving into DECODE
      exp_instr += 1;
      exp_cycle += 11;
      n_checks++;
      if (instr_cnt !== 32'(exp_instr) || cycle_cnt !== 32'(exp_cycle)) begin
         n_fails++;
         $display("FAIL wait_edge_cnts: got %0d/%0d want %0d/%0d", instr_cnt, cycle_cnt, exp_instr, exp_cycle);
      end
      opcode = 6'h00; funct = 6'h20;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      exp_instr += 1;
      exp_cycle += 3;
   endtask

   task automatic test_illegal();
      logic [16:0] ev [5];
      ev = '{V_FRDY, V_ZERO, V_ERR, V_ERR, V_ERR};
      opcode = 6'h3F; funct = 6'h00; mem_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== ev[i]) begin
            n_fails++;
            $display("FAIL illegal cyc%0d: got %b want %b", i, obs, ev[i]);
         end
         @(posedge clk); #1;
      end
      exp_cycle += 2;
      n_checks++;
      if (instr_cnt !== 32'(exp_instr) || cycle_cnt !== 32'(exp_cycle)) begin
         n_fails++;
         $display("FAIL illegal_cnts: got %0d/%0d want %0d/%0d", instr_cnt, cycle_cnt, exp_instr, exp_cycle);
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (obs !== V_ZERO) begin
         n_fails++;
         $display("FAIL illegal_rst: got %b want %b", obs, V_ZERO);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      exp_instr = 0;
      exp_cycle = 0;
      n_checks++;
      if (instr_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin
         n_fails++;
         $display("FAIL illegal_rst_cnts: got %0d/%0d want 0/0", instr_cnt, cycle_cnt);
      end
   endtask

   task automatic test_timeout();
      logic [16:0] ev [7];
      ev = '{V_FWAIT, V_FWAIT, V_FWAIT, V_FWAIT, V_ERR, V_ERR, V_ERR};
      opcode = 6'h00; funct = 6'h20; mem_rdy = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (i == 5) mem_rdy = 1'b1;
         @(negedge clk);
         n_checks++;
         if (obs !== ev[i]) begin
            n_fails++;
            $display("FAIL timeout cyc%0d: got %b want %b", i, obs, ev[i]);
         end
         @(posedge clk); #1;
      end
      exp_cycle += 4;
      n_checks++;
      if (instr_cnt !== 32'(exp_instr) || cycle_cnt !== 32'(exp_cycle)) begin
         n_fails++;
         $display("FAIL timeout_cnts: got %0d/%0d want %0d/%0d", instr_cnt, cycle_cnt, exp_instr, exp_cycle);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_instr = 0;
      exp_cycle = 0;
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw();
      test_branch();
      test_jump();
      test_itype();
      test_wait_edge();
      test_illegal();
      test_timeout();
      test_rtype();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
